// File: rtl/ripple_carry_adder_cell.sv
// Purpose: single-bit full adder, one link of the ripple carry chain.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared between the sum bit and the carry-propagate path.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Purpose: N-bit unsigned ripple-carry adder, {Cout,Sum} = A + B + Cin, plus a registered copy.
// Latency: Sum/Cout combinational (0 cycles); Sum_q/Cout_q exactly 1 cycle, captured every edge.
// Backpressure: none; no enable or handshake, the output register loads on every rising clk.
module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] Sum_q,
  output logic         Cout_q
);

  // c[i] is the carry into bit i; c[N] is the carry out of the top bit.
  logic [N:0] c;

  assign c[0] = Cin;

  // One explicit full-adder cell per bit, carry wired cell to cell.
  for (genvar i = 0; i < N; i++) begin : g_chain
    full_adder_cell u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (Sum[i]),
      .co (c[i+1])
    );
  end

  assign Cout = c[N];

  // Output register: synchronous clear, otherwise capture the combinational result every cycle.
  // Reset only touches this register; the combinational result stays live during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q  <= '0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= Sum;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
module tb_ripple_carry_adder;

  localparam int N = 8;

  logic [N-1:0] A, B, Sum, Sum_q;
  logic         Cin, Cout, Cout_q;
  logic         clk, rst;
  logic         clk_run;

  int n_cmp = 0;
  int n_bad = 0;

  ripple_carry_adder #(.N(N)) dut (
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .clk    (clk),
    .rst    (rst),
    .Sum_q  (Sum_q),
    .Cout_q (Cout_q)
  );

  // Gated clock so the long combinational sweep does not burn clock cycles.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
  } vec_t;

  // Reference: plain N+1-bit unsigned arithmetic.
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin);
    logic [N:0] r;
    r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    return r;
  endfunction

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cout,sum}=%h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                       input logic r);
    @(negedge clk);
    A = a; B = b; Cin = cin; rst = r;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[6];
  logic [N:0] exp_c;
  logic [N:0] exp_q;
  logic       r_bit;
  logic [16:0] sv;
  logic        sweep_bad;

  initial begin
    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[3] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, sum: 8'hFF, cout: 1'b0};
    vecs[4] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};

    clk_run = 1'b1;
    rst = 1'b1; A = '0; B = '0; Cin = 1'b0;

    // Reset state of the registered outputs.
    edge_sample();
    edge_sample();
    check("reset_state_q", {Cout_q, Sum_q}, 9'h000);

    // Directed table: combinational result, then its registered copy one edge later.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      #1;
      check($sformatf("table%0d_comb", i), {Cout, Sum}, {vecs[i].cout, vecs[i].sum});
      edge_sample();
      check($sformatf("table%0d_q", i), {Cout_q, Sum_q}, {vecs[i].cout, vecs[i].sum});
    end

    // Reset held for two edges: register stays clear while the comb path keeps working.
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    edge_sample();
    check("rst_hold1_q", {Cout_q, Sum_q}, 9'h000);
    check("rst_hold1_comb", {Cout, Sum}, 9'h046);
    edge_sample();
    check("rst_hold2_q", {Cout_q, Sum_q}, 9'h000);
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    edge_sample();
    check("rst_release_q", {Cout_q, Sum_q}, 9'h046);

    // Reset asserted mid-stream for a single edge.
    drive(8'h64, 8'h64, 1'b0, 1'b0);
    edge_sample();
    check("mid_pre_q", {Cout_q, Sum_q}, 9'h0C8);
    drive(8'h64, 8'h64, 1'b0, 1'b1);
    #1;
    check("mid_rst_comb", {Cout, Sum}, 9'h0C8);
    edge_sample();
    check("mid_rst_q", {Cout_q, Sum_q}, 9'h000);
    check("mid_rst_comb_after", {Cout, Sum}, 9'h0C8);
    drive(8'h64, 8'h64, 1'b0, 1'b0);
    edge_sample();
    check("mid_post_q", {Cout_q, Sum_q}, 9'h0C8);

    // Randomised stream with occasional reset against the arithmetic model.
    for (int k = 0; k < 300; k++) begin
      r_bit = ($urandom_range(0, 9) == 0);
      drive(N'($urandom), N'($urandom), 1'($urandom), r_bit);
      exp_c = ref_add(A, B, Cin);
      exp_q = r_bit ? '0 : exp_c;
      #1;
      check("rand_comb", {Cout, Sum}, exp_c);
      edge_sample();
      check("rand_q", {Cout_q, Sum_q}, exp_q);
    end

    // Exhaustive combinational sweep with the clock parked.
    @(negedge clk);
    clk_run = 1'b0;
    rst = 1'b0;
    sweep_bad = 1'b0;
    for (int v = 0; v < (1 << 17); v++) begin
      sv = 17'(v);
      {Cin, B, A} = sv;
      #10;
      exp_c = ref_add(sv[7:0], sv[15:8], sv[16]);
      n_cmp++;
      if ({Cout, Sum} !== exp_c) begin
        n_bad++;
        sweep_bad = 1'b1;
        $display("FAIL sweep A=%h B=%h Cin=%b: got %h, want %h", A, B, Cin, {Cout, Sum}, exp_c);
      end
      if (sweep_bad) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
